// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//   Shares one 16-bit asynchronous SRAM between two 32-bit requesters (A, B).
//   Each 32-bit access is split into two halfword phases. Each phase has one
//   access cycle (ACC) and one recovery/hold cycle (REC). Halfword 0 carries
//   data bits 31:16 and halfword 1 carries bits 15:0 (big-endian). When both
//   ports request in the same IDLE cycle, round-robin picks the port that was
//   not granted last. All SRAM strobes, the address, the acks and the read
//   data are registered outputs.
//
// Ports
//   clk, reset              : 50 MHz clock; asynchronous active-high reset
//   a_/b_req, a_/b_we       : request (held until ack), 1 = write
//   a_/b_addr [16:0]        : 32-bit word address
//   a_/b_sel  [3:0]         : byte enables, sel[3] -> bits 31:24
//   a_/b_wdata[31:0]        : write data
//   a_/b_rdata[31:0]        : registered read data, valid with ack
//   a_/b_ack                : one-cycle completion pulse
//   sram_addr [17:0]        : halfword address {word_addr, half}
//   sram_dq   [15:0]        : bidirectional SRAM data bus
//   sram_ce_n/oe_n/we_n/ub_n/lb_n : active-low SRAM strobes (ub = dq[15:8])
//
// Build option
//   SRAM_ARB_HALF_SKIP_EN : on writes, skip any halfword whose two byte
//                           enables are both clear. Reads always run both
//                           halves.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [16:0] a_addr,
    input  logic [16:0] b_addr,
    input  logic [3:0]  a_sel,
    input  logic [3:0]  b_sel,
    input  logic [31:0] a_wdata,
    input  logic [31:0] b_wdata,
    output logic [31:0] a_rdata,
    output logic [31:0] b_rdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {IDLE, H0_ACC, H0_REC, H1_ACC, H1_REC, ACK} state_t;

    state_t       state, state_nx;
    logic         last_b;       // 1 = B was granted last, so A wins the next tie
    logic         owner_b;      // port that owns the transaction in flight
    logic         we_q;
    logic [16:0]  addr_q;
    logic [3:0]   sel_q;
    logic [31:0]  wdata_q;
    logic [15:0]  rd_hi, rd_lo;
    logic [15:0]  dq_out;
    logic         dq_oe;

    // Transaction fields as seen this cycle: in IDLE they come straight from
    // the winning port, so the first phase can be set up on the grant edge.
    logic         gnt_b;
    logic         t_owner_b;
    logic         t_we;
    logic [16:0]  t_addr;
    logic [3:0]   t_sel;
    logic [31:0]  t_wdata;
    logic         skip_h0, skip_h1;

    // Strobes presented during state s: {ce_n, oe_n, we_n, ub_n, lb_n}.
    // In an ACC state a read pulls oe_n low and a write pulls we_n low.
    // A REC state releases both strobes. This gives read bus turnaround and
    // write data hold.
    function automatic logic [4:0] strobes(state_t s, logic we, logic [3:0] sel);
        case (s)
            H0_ACC:  strobes = {1'b0, we,   ~we,  ~sel[3], ~sel[2]};
            H0_REC:  strobes = {1'b0, 1'b1, 1'b1, ~sel[3], ~sel[2]};
            H1_ACC:  strobes = {1'b0, we,   ~we,  ~sel[1], ~sel[0]};
            H1_REC:  strobes = {1'b0, 1'b1, 1'b1, ~sel[1], ~sel[0]};
            default: strobes = 5'b11111;
        endcase
    endfunction

    always_comb begin
        gnt_b = b_req && (!a_req || !last_b);
        if (state == IDLE) begin
            t_owner_b = gnt_b;
            t_we      = gnt_b ? b_we    : a_we;
            t_addr    = gnt_b ? b_addr  : a_addr;
            t_sel     = gnt_b ? b_sel   : a_sel;
            t_wdata   = gnt_b ? b_wdata : a_wdata;
        end else begin
            t_owner_b = owner_b;
            t_we      = we_q;
            t_addr    = addr_q;
            t_sel     = sel_q;
            t_wdata   = wdata_q;
        end

        skip_h0 = 1'b0;
        skip_h1 = 1'b0;
`ifdef SRAM_ARB_HALF_SKIP_EN
        skip_h0 = t_we && (t_sel[3:2] == 2'b00);
        skip_h1 = t_we && (t_sel[1:0] == 2'b00);
`endif

        state_nx = state;
        case (state)
            IDLE:    if (a_req || b_req)
                         state_nx = skip_h0 ? (skip_h1 ? ACK : H1_ACC) : H0_ACC;
            H0_ACC:  state_nx = H0_REC;
            H0_REC:  state_nx = skip_h1 ? ACK : H1_ACC;
            H1_ACC:  state_nx = H1_REC;
            H1_REC:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control, strobes and port outputs (registered, cleared by reset)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            owner_b   <= 1'b0;
            {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} <= 5'b11111;
            sram_addr <= '0;
            dq_oe     <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            a_rdata   <= '0;
            b_rdata   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                owner_b <= t_owner_b;
                if (a_req || b_req)
                    last_b <= gnt_b;
            end

            {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} <= strobes(state_nx, t_we, t_sel);
            dq_oe <= t_we && (state_nx inside {H0_ACC, H0_REC, H1_ACC, H1_REC});
            if (state_nx inside {H0_ACC, H0_REC})
                sram_addr <= {t_addr, 1'b0};
            else if (state_nx inside {H1_ACC, H1_REC})
                sram_addr <= {t_addr, 1'b1};

            a_ack <= (state_nx == ACK) && !t_owner_b;
            b_ack <= (state_nx == ACK) &&  t_owner_b;
            if (state_nx == ACK && !t_we) begin
                if (t_owner_b)
                    b_rdata <= {rd_hi, rd_lo};
                else
                    a_rdata <= {rd_hi, rd_lo};
            end
        end
    end

    // Datapath: transaction latch, read capture, write data (no reset needed)
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            we_q    <= t_we;
            addr_q  <= t_addr;
            sel_q   <= t_sel;
            wdata_q <= t_wdata;
        end
        // Read data is sampled at the end of each ACC cycle while oe_n is low.
        if (state == H0_ACC && !we_q)
            rd_hi <= sram_dq;
        if (state == H1_ACC && !we_q)
            rd_lo <= sram_dq;
        if (state_nx inside {H0_ACC, H0_REC})
            dq_out <= t_wdata[31:16];
        else if (state_nx inside {H1_ACC, H1_REC})
            dq_out <= t_wdata[15:0];
    end

    assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req, a_we, b_we;
    logic [16:0] a_addr, b_addr;
    logic [3:0]  a_sel, b_sel;
    logic [31:0] a_wdata, b_wdata;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [17:0] sram_addr;
    wire  [15:0] sram_dq;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram_mem [0:262143];   // physical halfword SRAM
    logic [31:0] ref_mem  [int];        // word-level reference contents
    bit          txn_we;                // current transaction is a write
    bit          last_h0_touched;
    int          last_n;

    always #10 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr), .a_sel(a_sel), .b_sel(b_sel),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_rdata(a_rdata), .b_rdata(b_rdata), .a_ack(a_ack), .b_ack(b_ack),
        .sram_addr(sram_addr), .sram_dq(sram_dq),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // SRAM device model
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;

    always @(negedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq[15:8];
            if (!sram_lb_n) sram_mem[sram_addr][7:0]  = sram_dq[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bus discipline monitor
    always @(negedge clk) begin
        check("we_oe_excl", 32'(!sram_we_n && !sram_oe_n), 0);
        if (!(!sram_ce_n && !sram_oe_n && sram_we_n))
            check("dq_drive", 32'(sram_dq !== 16'hzzzz), 32'(txn_we && !sram_ce_n));
    end

    // Reference model helpers
    function automatic logic [31:0] ref_get(input logic [16:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] w;
        w = old;
        for (int i = 0; i < 4; i++)
            if (sel[i]) w[8*i +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    function automatic int exp_lat(input bit we, input logic [3:0] sel);
        int do_h0, do_h1;
        do_h0 = 1;
        do_h1 = 1;
`ifdef SRAM_ARB_HALF_SKIP_EN
        do_h0 = (!we || sel[3:2] != 2'b00) ? 1 : 0;
        do_h1 = (!we || sel[1:0] != 2'b00) ? 1 : 0;
`endif
        return 1 + 2 * do_h0 + 2 * do_h1;
    endfunction

    // One transaction on port p (0 = A, 1 = B), started in an IDLE cycle.
    task automatic do_txn(input bit p, input bit we, input logic [16:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          output logic [31:0] rd);
        int n, lat;
        logic [31:0] own0, oth0, own, oth;
        logic own_ack;
        lat  = exp_lat(we, sel);
        own0 = p ? b_rdata : a_rdata;
        oth0 = p ? a_rdata : b_rdata;
        txn_we = we;
        if (!p) begin
            a_we = we; a_addr = addr; a_sel = sel; a_wdata = wd; a_req = 1'b1;
        end else begin
            b_we = we; b_addr = addr; b_sel = sel; b_wdata = wd; b_req = 1'b1;
        end
        n = 0;
        last_h0_touched = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            own_ack = p ? b_ack : a_ack;
            if (!sram_ce_n && sram_addr == {addr, 1'b0}) last_h0_touched = 1'b1;
            check("other_ack", 32'(p ? a_ack : b_ack), 0);
            if (n == 1 && lat == 5) begin
                check("h0_addr", 32'(sram_addr), 32'({addr, 1'b0}));
                check("h0_strobe", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
                      {27'd0, 1'b0, we, !we, !sel[3], !sel[2]});
            end
        end while (!own_ack && n < 20);
        last_n = n;
        check("ack_lat", n, lat);
        if (!p) a_req = 1'b0; else b_req = 1'b0;
        own = p ? b_rdata : a_rdata;
        oth = p ? a_rdata : b_rdata;
        check("oth_rdata_hold", oth, oth0);
        if (we) begin
            ref_mem[int'(addr)] = merge(ref_get(addr), wd, sel);
            check("wr_rdata_hold", own, own0);
        end else begin
            check("rd_data", own, ref_get(addr));
        end
        rd = own;
        @(posedge clk); #1;
        check("ack_pulse", 32'(p ? b_ack : a_ack), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        a_req = 0; b_req = 0; a_we = 0; b_we = 0;
        a_addr = 0; b_addr = 0; a_sel = 0; b_sel = 0; a_wdata = 0; b_wdata = 0;
        txn_we = 0;
        do_reset();

        // Reset state
        check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_acks", {30'd0, a_ack, b_ack}, 0);
        check("rst_a_rdata", a_rdata, 0);
        check("rst_b_rdata", b_rdata, 0);
        check("rst_dq_z", 32'(sram_dq === 16'hzzzz), 1);

        // Write then read back
        do_txn(0, 1, 17'h00010, 4'b1111, 32'hDEADBEEF, rd);
        check("mem_h0", 32'(sram_mem[18'h00020]), 32'hDEAD);
        check("mem_h1", 32'(sram_mem[18'h00021]), 32'hBEEF);
        do_txn(0, 0, 17'h00010, 4'b1111, 32'h0, rd);
        check("wr_rd_a", rd, 32'hDEADBEEF);

        // Byte write over a preset word
        do_txn(1, 1, 17'h00003, 4'b1111, 32'h11223344, rd);
        do_txn(1, 1, 17'h00003, 4'b0100, 32'h00AB0000, rd);
        do_txn(1, 0, 17'h00003, 4'b0000, 32'h0, rd);
        check("byte_wr", rd, 32'h11AB3344);

        // Half-skip option: only halfword 1 is touched when it is enabled
        do_txn(0, 1, 17'h00005, 4'b1111, 32'h01020304, rd);
        do_txn(0, 1, 17'h00005, 4'b0011, 32'h0000CAFE, rd);
`ifdef SRAM_ARB_HALF_SKIP_EN
        check("skip_lat", last_n, 3);
        check("skip_h0_touch", 32'(last_h0_touched), 0);
`else
        check("skip_lat", last_n, 5);
        check("skip_h0_touch", 32'(last_h0_touched), 1);
`endif
        do_txn(1, 0, 17'h00005, 4'b1111, 32'h0, rd);
        check("skip_rd", rd, 32'h0102CAFE);

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   17'($urandom_range(0, 7)), 4'($urandom), $urandom, rd);
        end

        // Contention: both request together after reset, held continuously
        do_reset();
        txn_we = 0;
        a_we = 0; a_addr = 17'd1; a_sel = 4'hF;
        b_we = 0; b_addr = 17'd2; b_sel = 4'hF;
        a_req = 1; b_req = 1;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            check("both_ack", 32'(a_ack && b_ack), 0);
            check("cont_a_ack", 32'(a_ack), 32'(c == 5 || c == 17));
            check("cont_b_ack", 32'(b_ack), 32'(c == 11 || c == 23));
            if (c == 5)  check("cont_a_rd", a_rdata, ref_get(17'd1));
            if (c == 11) check("cont_b_rd", b_rdata, ref_get(17'd2));
            if (c == 23) begin a_req = 0; b_req = 0; end
        end

        // Reset during the H1 access of a write
        txn_we = 1;
        a_we = 1; a_addr = 17'h1F000; a_sel = 4'hF; a_wdata = 32'h55AA55AA; a_req = 1;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_pre_we", 32'(sram_we_n), 0);
        reset = 1'b1;
        #1;
        check("abort_we_n", 32'(sram_we_n), 1);
        check("abort_ce_n", 32'(sram_ce_n), 1);
        check("abort_dq_z", 32'(sram_dq === 16'hzzzz), 1);
        a_req = 0;
        txn_we = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {30'd0, a_ack, b_ack}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
